traffic_phase_ctrl: RTL and testbench

- Phase sequencer for one two-road intersection with a pedestrian crossing.
- Owns the 6-bit cycle counter consumed by the enable-timing block; consumes that block's `enable` as its phase-advance request.
- Drives the main/side signal heads and the walk lamp, and latches pedestrian button presses into a per-cycle `ped_cycle` flag that feeds the timing block's PED input.

---
 rtl/traffic_phase_ctrl_pkg.sv | 44 ++++
 rtl/traffic_phase_ctrl_if.sv | 29 ++
 rtl/traffic_phase_ctrl_ped_request_latch.sv | 39 +++
 rtl/traffic_phase_ctrl.sv | 141 ++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_phase_ctrl_pkg.sv
// traffic_pkg: shared types and constants for the intersection phase sequencer.
//   phase_e        - phase encoding driven on the phase output
//   LIGHT_*        - one-hot {red,yellow,green} signal-head patterns
//   main/side_light_of - steady-state head decode for a phase
package traffic_pkg;

  localparam int unsigned CNT_W_DEFAULT   = 6;
  localparam int unsigned CNT_MAX_DEFAULT = 63;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_OFF    = 3'b000;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5,
    PED_WALK    = 3'd6,
    FAULT       = 3'd7
  } phase_e;

  // Main head: anything other than the two main phases shows red (incl. code 7).
  function automatic logic [2:0] main_light_of(input phase_e p);
    case (p)
      MAIN_GREEN:  return LIGHT_GREEN;
      MAIN_YELLOW: return LIGHT_YELLOW;
      default:     return LIGHT_RED;
    endcase
  endfunction

  // Side head: anything other than the two side phases shows red (incl. code 7).
  function automatic logic [2:0] side_light_of(input phase_e p);
    case (p)
      SIDE_GREEN:  return LIGHT_GREEN;
      SIDE_YELLOW: return LIGHT_YELLOW;
      default:     return LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// traffic_phase_ctrl_if: timing-block / signal-head bundle for traffic_phase_ctrl.
//   master: drives tick, adv, ped_btn; observes counter, ped_cycle, phase, lights, walk
//   slave : the phase sequencer side
interface traffic_phase_ctrl_if #(
  parameter int unsigned CNT_W = traffic_pkg::CNT_W_DEFAULT
);
  import traffic_pkg::*;

  logic             tick;
  logic             adv;
  logic             ped_btn;
  logic [CNT_W-1:0] counter;
  logic             ped_cycle;
  phase_e           phase;
  logic [2:0]       main_light;
  logic [2:0]       side_light;
  logic             walk;

  modport master (
    output tick, adv, ped_btn,
    input  counter, ped_cycle, phase, main_light, side_light, walk
  );

  modport slave (
    input  tick, adv, ped_btn,
    output counter, ped_cycle, phase, main_light, side_light, walk
  );

endinterface

// File: rtl/traffic_phase_ctrl_ped_request_latch.sv
// ped_request_latch: captures pedestrian presses and freezes them into a
// per-cycle ped_cycle flag at the start of each signal cycle.
//   clk, reset (async, active-low)
//   ped_btn     - synchronised button level/pulse
//   cycle_start - this edge enters MAIN_GREEN
//   walk_active - current phase is PED_WALK; presses are discarded
//   ped_cycle   - current cycle includes a walk phase
module ped_request_latch (
  input  logic clk,
  input  logic reset,
  input  logic ped_btn,
  input  logic cycle_start,
  input  logic walk_active,
  output logic ped_cycle
);

  logic r_ped_pending;
  logic r_ped_cycle;
  logic w_press;

  // A press seen while walking is already being served, so drop it.
  assign w_press = ped_btn & ~walk_active;

  // A press on the very edge that starts a cycle still counts for that cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ped_pending <= 1'b0;
      r_ped_cycle   <= 1'b0;
    end else if (cycle_start) begin
      r_ped_cycle   <= r_ped_pending | w_press;
      r_ped_pending <= 1'b0;
    end else if (w_press) begin
      r_ped_pending <= 1'b1;
    end
  end

  assign ped_cycle = r_ped_cycle;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: phase sequencer for a two-road intersection with a
// pedestrian crossing. Owns the cycle counter fed to the timing block and
// advances one phase per tick-qualified adv.
//   clk, reset (async, active-low)
//   bus.tick/adv/ped_btn                 - timebase strobe, advance request, button
//   bus.counter/ped_cycle                - to the timing block
//   bus.phase/main_light/side_light/walk - signal heads, all registered
// Optional: define TRAFFIC_WDT_EN to enter a latched flashing FAULT phase when
// the counter sits at CNT_MAX on a tick without an advance.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  traffic_phase_ctrl_if.slave  bus
);

  phase_e           r_phase;
  phase_e           w_phase_nxt;
  logic [CNT_W-1:0] r_counter;
  logic [CNT_W-1:0] w_counter_nxt;
  logic [2:0]       r_main;
  logic [2:0]       w_main_nxt;
  logic [2:0]       r_side;
  logic [2:0]       w_side_nxt;
  logic             r_walk;
  logic             w_walk_nxt;
  logic             w_cycle_start;
  logic             w_walk_active;
  logic             w_ped_cycle;
`ifdef TRAFFIC_WDT_EN
  logic             r_flash;
  logic             w_flash_nxt;
`endif

  assign w_walk_active = (r_phase == PED_WALK);

  ped_request_latch u_ped_latch (
    .clk         (clk),
    .reset       (reset),
    .ped_btn     (bus.ped_btn),
    .cycle_start (w_cycle_start),
    .walk_active (w_walk_active),
    .ped_cycle   (w_ped_cycle)
  );

  // Next phase, counter and registered head patterns.
  always_comb begin
    w_phase_nxt   = r_phase;
    w_counter_nxt = r_counter;
    w_cycle_start = 1'b0;
    w_main_nxt    = LIGHT_RED;
    w_side_nxt    = LIGHT_RED;
    w_walk_nxt    = 1'b0;
`ifdef TRAFFIC_WDT_EN
    w_flash_nxt   = r_flash;
`endif

    if (bus.tick) begin
      if (bus.adv) begin
        case (r_phase)
          MAIN_GREEN:  w_phase_nxt = MAIN_YELLOW;
          MAIN_YELLOW: w_phase_nxt = ALL_RED_A;
          ALL_RED_A:   w_phase_nxt = SIDE_GREEN;
          SIDE_GREEN:  w_phase_nxt = SIDE_YELLOW;
          SIDE_YELLOW: w_phase_nxt = ALL_RED_B;
          ALL_RED_B:   w_phase_nxt = w_ped_cycle ? PED_WALK : MAIN_GREEN;
          PED_WALK:    w_phase_nxt = MAIN_GREEN;
          default:     w_phase_nxt = r_phase;
        endcase
      end
`ifdef TRAFFIC_WDT_EN
      else if (r_counter == CNT_W'(CNT_MAX)) begin
        w_phase_nxt = FAULT;
      end
`endif
    end

    w_cycle_start = (r_phase != MAIN_GREEN) && (w_phase_nxt == MAIN_GREEN);

    // Counter freezes in FAULT; elsewhere restarts per cycle and saturates.
    if (bus.tick && (r_phase != FAULT)) begin
      if (w_cycle_start) begin
        w_counter_nxt = '0;
      end else if (r_counter != CNT_W'(CNT_MAX)) begin
        w_counter_nxt = r_counter + CNT_W'(1);
      end
    end

    w_main_nxt = main_light_of(w_phase_nxt);
    w_side_nxt = side_light_of(w_phase_nxt);
    w_walk_nxt = (w_phase_nxt == PED_WALK);

`ifdef TRAFFIC_WDT_EN
    // FAULT flashes all-red: lit on entry, then toggles on every tick.
    if (w_phase_nxt == FAULT) begin
      if (r_phase != FAULT) begin
        w_flash_nxt = 1'b1;
      end else if (bus.tick) begin
        w_flash_nxt = ~r_flash;
      end
      w_main_nxt = w_flash_nxt ? LIGHT_RED : LIGHT_OFF;
      w_side_nxt = w_flash_nxt ? LIGHT_RED : LIGHT_OFF;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase   <= MAIN_GREEN;
      r_counter <= '0;
      r_main    <= LIGHT_GREEN;
      r_side    <= LIGHT_RED;
      r_walk    <= 1'b0;
`ifdef TRAFFIC_WDT_EN
      r_flash   <= 1'b0;
`endif
    end else begin
      r_phase   <= w_phase_nxt;
      r_counter <= w_counter_nxt;
      r_main    <= w_main_nxt;
      r_side    <= w_side_nxt;
      r_walk    <= w_walk_nxt;
`ifdef TRAFFIC_WDT_EN
      r_flash   <= w_flash_nxt;
`endif
    end
  end

  assign bus.phase      = r_phase;
  assign bus.counter    = r_counter;
  assign bus.main_light = r_main;
  assign bus.side_light = r_side;
  assign bus.walk       = r_walk;
  assign bus.ped_cycle  = w_ped_cycle;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: a reference model produces the expected
// outputs for every driven clk, queued and compared one clk later.
`timescale 1ns/1ps
module tb_traffic_phase_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  traffic_phase_ctrl_if #(.CNT_W(6)) bus ();

  traffic_phase_ctrl #(.CNT_W(6), .CNT_MAX(63)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0] phase;
    logic [5:0] counter;
    logic [2:0] main_l;
    logic [2:0] side_l;
    logic       walk;
    logic       ped_cycle;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  logic [2:0] m_phase;
  int         m_cnt;
  logic       m_pend, m_pc, m_flash;
  logic       walk_btn;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {main,side} head pattern for a phase
  function automatic logic [5:0] heads(input logic [2:0] p, input logic fl);
    case (p)
      3'd0:    return 6'b001_100;
      3'd1:    return 6'b010_100;
      3'd3:    return 6'b100_001;
      3'd4:    return 6'b100_010;
      3'd7:    return fl ? 6'b100_100 : 6'b000_000;
      default: return 6'b100_100;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 3'd0; m_cnt = 0; m_pend = 1'b0; m_pc = 1'b0; m_flash = 1'b0;
  endtask

  task automatic model_step(input logic t, input logic a, input logic b);
    logic [2:0] nxt;
    logic       enter_green;
    nxt = m_phase;
    if (t && m_phase != 3'd7) begin
      if (a) begin
        if (m_phase == 3'd5)      nxt = m_pc ? 3'd6 : 3'd0;
        else if (m_phase == 3'd6) nxt = 3'd0;
        else                      nxt = m_phase + 3'd1;
      end
`ifdef TRAFFIC_WDT_EN
      else if (m_cnt == 63) nxt = 3'd7;
`endif
    end
    enter_green = (nxt == 3'd0) && (m_phase != 3'd0);
    if (enter_green) begin
      m_pc   = m_pend | (b && m_phase != 3'd6);
      m_pend = 1'b0;
    end else if (b && m_phase != 3'd6) begin
      m_pend = 1'b1;
    end
    if (t && m_phase != 3'd7) m_cnt = enter_green ? 0 : ((m_cnt >= 63) ? 63 : m_cnt + 1);
    if (nxt == 3'd7) m_flash = (m_phase != 3'd7) ? 1'b1 : (t ? ~m_flash : m_flash);
    m_phase = nxt;
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL sb_underflow: got empty queue expected an entry at %0t", $time);
      return;
    end
    e = sb_q.pop_front();
    check("phase",     32'(bus.phase),      32'(e.phase));
    check("counter",   32'(bus.counter),    32'(e.counter));
    check("main",      32'(bus.main_light), 32'(e.main_l));
    check("side",      32'(bus.side_light), 32'(e.side_l));
    check("walk",      32'(bus.walk),       32'(e.walk));
    check("ped_cycle", 32'(bus.ped_cycle),  32'(e.ped_cycle));
  endtask

  // Drive one clk of stimulus (called at a negedge), queue the expectation, compare after the edge.
  task automatic step(input logic t, input logic a, input logic b);
    exp_t       e;
    logic [5:0] h;
    bus.tick = t; bus.adv = a; bus.ped_btn = b;
    model_step(t, a, b);
    h = heads(m_phase, m_flash);
    e.phase = m_phase; e.counter = 6'(m_cnt);
    e.main_l = h[5:3]; e.side_l = h[2:0];
    e.walk = (m_phase == 3'd6); e.ped_cycle = m_pc;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    compare_out();
  endtask

  // Tick with adv low until the counter reaches target, then tick with adv high.
  task automatic adv_at(input int target, input logic btn_on_adv);
    int guard;
    guard = 0;
    while (m_cnt != target) begin
      if (guard++ > 100) begin
        n_checks++; n_fail++;
        $display("FAIL adv_at_timeout: counter %0d expected %0d", m_cnt, target);
        return;
      end
      step(1'b1, 1'b0, walk_btn && (m_phase == 3'd6));
    end
    step(1'b1, 1'b1, btn_on_adv || (walk_btn && (m_phase == 3'd6)));
  endtask

  task automatic std_cycle(input logic btn_last);
    adv_at(11, 1'b0); adv_at(13, 1'b0); adv_at(15, 1'b0);
    adv_at(25, 1'b0); adv_at(27, 1'b0); adv_at(29, btn_last);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_phase"},   32'(bus.phase),      32'd0);
    check({tag, "_counter"}, 32'(bus.counter),    32'd0);
    check({tag, "_main"},    32'(bus.main_light), 32'b001);
    check({tag, "_side"},    32'(bus.side_light), 32'b100);
    check({tag, "_walk"},    32'(bus.walk),       32'd0);
    check({tag, "_pedcyc"},  32'(bus.ped_cycle),  32'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.tick = 1'b0; bus.adv = 1'b0; bus.ped_btn = 1'b0;
    walk_btn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Free-running count from reset
    repeat (5) step(1'b1, 1'b0, 1'b0);
    check("count5", 32'(bus.counter), 32'd5);

    // Normal cycle, no pedestrian
    std_cycle(1'b0);
    check("normal_end_phase",  32'(bus.phase),     32'd0);
    check("normal_end_cnt",    32'(bus.counter),   32'd0);
    check("normal_end_pedcyc", 32'(bus.ped_cycle), 32'd0);

    // Press at counter 5: served next cycle
    repeat (5) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    std_cycle(1'b0);
    check("pedA_end_phase",  32'(bus.phase),     32'd0);
    check("pedA_end_pedcyc", 32'(bus.ped_cycle), 32'd1);

    // Walk cycle, button held throughout PED_WALK
    walk_btn = 1'b1;
    std_cycle(1'b0);
    check("pedB_walk_phase", 32'(bus.phase), 32'd6);
    check("pedB_walk_lamp",  32'(bus.walk),  32'd1);
    adv_at(39, 1'b0);
    walk_btn = 1'b0;
    check("pedB_end_phase",  32'(bus.phase),     32'd0);
    check("pedB_end_pedcyc", 32'(bus.ped_cycle), 32'd0);

    // Press on the exact edge entering MAIN_GREEN
    std_cycle(1'b1);
    check("edge_press_pedcyc", 32'(bus.ped_cycle), 32'd1);

    // Tick gating
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b0);
    check("gate_cnt",   32'(bus.counter), 32'd3);
    check("gate_phase", 32'(bus.phase),   32'd0);
    step(1'b1, 1'b1, 1'b0);
    check("gate_adv_phase", 32'(bus.phase),   32'd1);
    check("gate_adv_cnt",   32'(bus.counter), 32'd4);
    step(1'b1, 1'b0, 1'b0);
    check("gate_once_phase", 32'(bus.phase), 32'd1);

    // Reset mid-phase with a pending press
    adv_at(13, 1'b0); adv_at(15, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    bus.tick = 1'b0; bus.adv = 1'b0; bus.ped_btn = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midreset");
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    std_cycle(1'b0);
    check("lost_press_pedcyc", 32'(bus.ped_cycle), 32'd0);

    // Long idle: saturation or watchdog
    repeat (70) step(1'b1, 1'b0, 1'b0);
`ifdef TRAFFIC_WDT_EN
    check("wdt_phase", 32'(bus.phase), 32'd7);
    repeat (3) step(1'b1, 1'b1, 1'b1);
    check("wdt_stuck", 32'(bus.phase), 32'd7);
    rst_n = 1'b0;
    #1 check_reset_vals("wdt_reset");
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0);
`else
    check("sat_cnt",   32'(bus.counter), 32'd63);
    check("sat_phase", 32'(bus.phase),   32'd0);
`endif

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
